imem_boot_responder: RTL and testbench
======================================

# imem_boot_responder

Instruction-fetch responder for the single-cycle RISC-V core: it answers the CPU's `PC` with `Instr`, combinationally within the same cycle. Before the CPU runs, it accepts a program as a little-endian byte stream over a valid/ready load port and packs the bytes into a word RAM. While loading it holds the CPU in reset, and it releases the CPU once the last byte is committed.

## Interface
Parameters:
- `DEPTH_WORDS`, default 256: instruction RAM depth in 32-bit words; must be a power of two.
- `AW`, default `$clog2(DEPTH_WORDS)`: word-index width.

Ports:
- `clk`  in  1: single clock; all state changes on the rising edge.
- `reset`  in  1: reset is synchronous and active-low; `reset`=0 at a rising edge resets the block.
- `PC`  in  32: CPU fetch address (byte address).
- `Instr`  out  32: fetched instruction, combinational from `PC` and the registered state.
- `cpu_hold`  out  1: drives the CPU's reset; 1 = CPU held.
- `ld_valid`  in  1: a load byte is present.
- `ld_ready`  out  1: the block accepts a load byte this cycle.
- `ld_byte`  in  8: load data byte.
- `ld_last`  in  1: this byte is the final byte of the program; qualified by `ld_valid`.
- `words_loaded`  out  AW+1: number of words committed to RAM.
- `overflow`  out  1: sticky flag; set when a byte arrives after RAM is full.

## Operation
- The state machine has two states, `LOAD` and `RUN`. Reset enters `LOAD`; there is no other path from `RUN` back to `LOAD`.
- A byte is accepted on a rising edge where `ld_valid && ld_ready`.
- `LOAD` behaviour:
  - `ld_ready` = 1 and `cpu_hold` = 1.
  - A 24-bit assembly register and a 2-bit `byte_phase` collect bytes little-endian: byte 0 goes to `[7:0]`, byte 3 goes to `[31:24]`.
  - When a byte is accepted with `byte_phase`=3, the full word is written to `mem[words_loaded]` on that same edge. `words_loaded` then increments and `byte_phase` returns to 0.
- `ld_last` accepted:
  - A partial word is padded with zero bytes in the upper lanes and written on the same edge.
  - `words_loaded` increments if any byte is present, including the last byte itself.
  - The state moves to `RUN` on that edge.
- RAM full: once `words_loaded == DEPTH_WORDS`, further accepted bytes are discarded, `overflow` is set, and `words_loaded` saturates. `ld_last` still moves the state to `RUN`.
- `RUN` behaviour:
  - `ld_ready` = 0 and `cpu_hold` = 0.
  - Fetch index is `idx = PC[AW+1:2]`.
  - `Instr = mem[idx]` when `PC[1:0]==0`, `PC[31:AW+2]==0` and `idx < words_loaded`.
  - In every other case `Instr = 32'h00000013` (NOP, `addi x0,x0,0`).
- In `LOAD`, `Instr = 32'h00000013` regardless of `PC`.
- RAM contents are not cleared by reset. Words at or above `words_loaded` are never visible to the CPU.

## Timing
- Reset values:
  - State `LOAD`, `byte_phase`=0, assembly register 0, `words_loaded`=0, `overflow`=0.
  - `cpu_hold`=1 and `Instr`=NOP.
  - `ld_ready`=0 while `reset`=0, because `ld_ready` is gated by `reset`. It is 1 from the first cycle with `reset`=1.
- Load throughput is one byte per cycle with no bubbles. The RAM write occurs on the accepting edge.
- `cpu_hold` falls on the edge that accepts `ld_last`. The CPU's first fetch with valid `Instr` is therefore the next cycle.
- Fetch latency is zero cycles: a combinational read, required by the single-cycle core.
- Reset mid-load: on the next edge the state, `byte_phase`, `words_loaded` and `overflow` return to reset values. Partial bytes in the assembly register are lost.
- `ld_valid` with `ld_ready`=0 is ignored. The block does not require `ld_valid` to stay asserted.

## Structure
- Shared package `imem_pkg`:
  - state enum `LOAD`/`RUN`.
  - `NOP_INSTR = 32'h00000013`.
  - byte-lane constants.
- One sub-module, `imem_ram`: a `DEPTH_WORDS`×32 RAM with one synchronous write port and one asynchronous read port. The top level holds the FSM, assembly logic, counters, range check and NOP mux.
- Expected size is 150–250 lines of RTL in total.

## Test plan
- Reset, then stream 8 bytes `13 05 10 00 93 05 20 00` with `ld_last` on byte 8 → `words_loaded`=2. `PC`=0 gives `Instr`=`00100513`; `PC`=4 gives `00200593`. `cpu_hold` falls on the last-byte edge.
- Stream 6 bytes `AA BB CC DD 11 22` with `ld_last` on byte 6 → word1 = `00002211`, `words_loaded`=2. `PC`=8 gives NOP.
- During `LOAD`, drive `PC`=0 → `Instr`=NOP and `cpu_hold`=1. In `RUN`, drive `PC`=2 (misaligned) → NOP; `PC`=`32'h00010000` (out of range) → NOP.
- With `DEPTH_WORDS`=4, stream 20 bytes with `ld_last` on byte 20 → `words_loaded`=4, `overflow`=1, state `RUN`, and words 0–3 match the first 16 bytes.
- Pulse `reset`=0 after 3 bytes, then load 4 bytes `01 02 03 04` with `ld_last` → word0 = `04030201`, `words_loaded`=1, `overflow`=0.
- Toggle `ld_valid` randomly in `LOAD` with gaps → same RAM contents as the gap-free run. In `RUN`, `ld_valid`=1 leaves `ld_ready`=0 and the state unchanged.

Source files
------------

// File: rtl/imem_boot_responder_pkg.sv
// Shared types and constants for the instruction-memory boot responder.
// Holds the FSM state enum, the NOP encoding and the byte-lane geometry.
package imem_pkg;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  localparam int BYTE_W    = 8;
  localparam int LANES     = 4;
  localparam int ASM_LANES = LANES - 1;

endpackage

// File: rtl/imem_boot_responder_if.sv
// Byte-stream load port: valid/ready handshake carrying one byte plus a last flag.
interface imem_boot_responder_if;
  import imem_pkg::*;

  logic              ld_valid;
  logic              ld_ready;
  logic [BYTE_W-1:0] ld_byte;
  logic              ld_last;

  modport master (
    output ld_valid,
    output ld_byte,
    output ld_last,
    input  ld_ready
  );

  modport slave (
    input  ld_valid,
    input  ld_byte,
    input  ld_last,
    output ld_ready
  );

endinterface

// File: rtl/imem_boot_responder_ram.sv
// Word RAM with one synchronous write port and one asynchronous read port.
// The asynchronous read is what lets the single-cycle core fetch in the same cycle.
module imem_ram #(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/imem_boot_responder.sv
// Instruction-fetch responder: packs a little-endian boot byte stream into word RAM
// while holding the CPU in reset, then serves combinational fetches with NOP fill.
module imem_boot_responder
  import imem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            PC,
  output logic [31:0]            Instr,
  output logic                   cpu_hold,
  imem_boot_responder_if.slave   ld,
  output logic [AW:0]            words_loaded,
  output logic                   overflow
);

  state_t                        state_reg;
  logic [1:0]                    byte_phase_reg;
  logic [ASM_LANES*BYTE_W-1:0]   asm_reg;
  logic [AW:0]                   words_loaded_reg;
  logic                          overflow_reg;
  logic                          cpu_hold_reg;

  logic                          accept;
  logic                          full;
  logic                          commit;
  logic [31:0]                   word_next;
  logic [31:0]                   rd_data;
  logic [AW-1:0]                 idx;
  logic                          in_range;

  // Ready is gated by reset so no byte can be taken while reset is asserted.
  assign ld.ld_ready = reset && (state_reg == LOAD);
  assign accept      = ld.ld_valid && ld.ld_ready;
  assign full        = (words_loaded_reg == (AW+1)'(DEPTH_WORDS));
  assign commit      = accept && !full && (ld.ld_last || (byte_phase_reg == 2'd3));

  // Lanes below the phase come from the assembly register, the current lane takes
  // the incoming byte, and lanes above are zero so a short last word is padded.
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      if (gi < ASM_LANES) begin : g_asm
        assign word_next[gi*BYTE_W +: BYTE_W] =
            (byte_phase_reg > 2'(gi))  ? asm_reg[gi*BYTE_W +: BYTE_W] :
            (byte_phase_reg == 2'(gi)) ? ld.ld_byte : '0;
      end else begin : g_top
        assign word_next[gi*BYTE_W +: BYTE_W] =
            (byte_phase_reg == 2'(gi)) ? ld.ld_byte : '0;
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg        <= LOAD;
      byte_phase_reg   <= '0;
      asm_reg          <= '0;
      words_loaded_reg <= '0;
      overflow_reg     <= 1'b0;
      cpu_hold_reg     <= 1'b1;
    end else if (accept) begin
      if (full) begin
        overflow_reg <= 1'b1;
      end else if (commit) begin
        words_loaded_reg <= words_loaded_reg + (AW+1)'(1);
        byte_phase_reg   <= '0;
      end else begin
        asm_reg[byte_phase_reg*BYTE_W +: BYTE_W] <= ld.ld_byte;
        byte_phase_reg                           <= byte_phase_reg + 2'd1;
      end
      if (ld.ld_last) begin
        state_reg    <= RUN;
        cpu_hold_reg <= 1'b0;
      end
    end
  end

  imem_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_ram (
    .clk   (clk),
    .we    (commit),
    .waddr (words_loaded_reg[AW-1:0]),
    .wdata (word_next),
    .raddr (idx),
    .rdata (rd_data)
  );

  // Misaligned, out-of-window or not-yet-loaded fetches all see a NOP.
  assign idx      = PC[AW+1:2];
  assign in_range = (PC[1:0] == 2'b00) && (PC[31:AW+2] == '0) &&
                    ({1'b0, idx} < words_loaded_reg);
  assign Instr    = ((state_reg == RUN) && in_range) ? rd_data : NOP_INSTR;

  assign cpu_hold     = cpu_hold_reg;
  assign words_loaded = words_loaded_reg;
  assign overflow     = overflow_reg;

endmodule

// File: tb/tb_imem_boot_responder.sv
// Randomized bench for imem_boot_responder: two instances (deep and 4-word) checked
// against a byte-queue reference model of load packing and fetch visibility.
module tb_imem_boot_responder;
  import imem_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset    = 1'b0;
  logic [31:0] pc       = '0;
  logic        ld_valid = 1'b0;
  logic        ld_last  = 1'b0;
  logic [7:0]  ld_byte  = '0;
  logic        sel      = 1'b0;

  imem_boot_responder_if ld_a ();
  imem_boot_responder_if ld_b ();

  assign ld_a.ld_valid = ld_valid & ~sel;
  assign ld_a.ld_byte  = ld_byte;
  assign ld_a.ld_last  = ld_last;
  assign ld_b.ld_valid = ld_valid & sel;
  assign ld_b.ld_byte  = ld_byte;
  assign ld_b.ld_last  = ld_last;

  logic [31:0] instr_a, instr_b;
  logic        hold_a, hold_b, ovf_a, ovf_b;
  logic [8:0]  words_a;
  logic [2:0]  words_b;

  imem_boot_responder #(.DEPTH_WORDS(256)) u_dut_a (
    .clk          (clk),
    .reset        (reset),
    .PC           (pc),
    .Instr        (instr_a),
    .cpu_hold     (hold_a),
    .ld           (ld_a),
    .words_loaded (words_a),
    .overflow     (ovf_a)
  );

  imem_boot_responder #(.DEPTH_WORDS(4)) u_dut_b (
    .clk          (clk),
    .reset        (reset),
    .PC           (pc),
    .Instr        (instr_b),
    .cpu_hold     (hold_b),
    .ld           (ld_b),
    .words_loaded (words_b),
    .overflow     (ovf_b)
  );

  logic [31:0] instr, words;
  logic        hold, ovf, ready;
  always_comb begin
    instr = sel ? instr_b : instr_a;
    hold  = sel ? hold_b  : hold_a;
    ovf   = sel ? ovf_b   : ovf_a;
    ready = sel ? ld_b.ld_ready : ld_a.ld_ready;
    words = sel ? 32'(words_b) : 32'(words_a);
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: every accepted byte in order, the RAM depth, and the run flag.
  logic [7:0] acc_q[$];
  int         depth = 256;
  bit         run_m = 1'b0;

  function automatic int m_count();
    int w;
    w = (acc_q.size() + 3) / 4;
    return (w > depth) ? depth : w;
  endfunction

  function automatic logic [31:0] m_word(input int k);
    logic [31:0] w;
    w = '0;
    for (int b = 0; b < 4; b++)
      if (4*k + b < acc_q.size()) w[8*b +: 8] = acc_q[4*k + b];
    return w;
  endfunction

  function automatic logic [31:0] m_instr(input logic [31:0] a);
    if (!run_m || a[1:0] != 2'b00) return NOP_INSTR;
    if ((a >> 2) < 32'(m_count())) return m_word(int'(a >> 2));
    return NOP_INSTR;
  endfunction

  task automatic select(input bit s);
    sel   = s;
    depth = s ? 4 : 256;
  endtask

  task automatic do_reset();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    reset    = 1'b0;
    pc       = $urandom;
    @(posedge clk); #1;
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_hold",  32'(hold),  32'd1);
    chk("rst_words", words,      32'd0);
    chk("rst_ovf",   32'(ovf),   32'd0);
    chk("rst_instr", instr,      NOP_INSTR);
    reset = 1'b1;
    acc_q.delete();
    run_m = 1'b0;
    #1;
    chk("ready_after_rst", 32'(ready), 32'd1);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit last, input int gap);
    repeat (gap) begin
      @(posedge clk); #1;
    end
    ld_valid = 1'b1;
    ld_byte  = b;
    ld_last  = last;
    pc       = $urandom_range(0, 63);
    #1;
    chk("ld_ready",   32'(ready), 32'd1);
    chk("hold_load",  32'(hold),  32'd1);
    chk("instr_load", instr,      NOP_INSTR);
    @(posedge clk); #1;
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    acc_q.push_back(b);
    if (last) begin
      run_m = 1'b1;
      chk("hold_fall", 32'(hold), 32'd0);
    end
  endtask

  task automatic load(input logic [7:0] pat[64], input int n, input int max_gap);
    for (int i = 0; i < n; i++)
      send_byte(pat[i], i == n - 1, (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
  endtask

  task automatic check_state();
    chk("words", words,    32'(m_count()));
    chk("ovf",   32'(ovf), 32'(acc_q.size() > 4*depth));
    chk("hold",  32'(hold), 32'(!run_m));
    chk("ready", 32'(ready), 32'(!run_m));
    for (int k = 0; k < m_count() + 2; k++) begin
      pc = 32'(4*k); #1;
      chk("fetch", instr, m_instr(pc));
    end
    pc = 32'(4*$urandom_range(0, 3)) + 32'($urandom_range(1, 3)); #1;
    chk("misalign", instr, m_instr(pc));
    pc = 32'h00010000; #1;
    chk("out_of_range", instr, m_instr(pc));
    repeat (3) begin
      pc = $urandom; #1;
      chk("rand_pc", instr, m_instr(pc));
    end
  endtask

  logic [7:0]  pat[64];
  logic [31:0] snap[64];
  logic [63:0] v64;
  int          n;

  initial begin
    // Directed program: two real instructions.
    select(1'b0);
    do_reset();
    pc = 32'h0; #1;
    chk("load_pc0_nop", instr, NOP_INSTR);
    v64 = 64'h00200593_00100513;
    for (int i = 0; i < 8; i++) send_byte(v64[8*i +: 8], i == 7, 0);
    check_state();
    pc = 32'd0; #1; chk("prog_w0", instr, 32'h00100513);
    pc = 32'd4; #1; chk("prog_w1", instr, 32'h00200593);
    pc = 32'd2; #1; chk("prog_mis", instr, NOP_INSTR);

    // Partial last word padded with zeros.
    do_reset();
    v64 = 64'h0000_2211_DDCC_BBAA;
    for (int i = 0; i < 6; i++) send_byte(v64[8*i +: 8], i == 5, 0);
    check_state();
    pc = 32'd4; #1; chk("pad_w1", instr, 32'h00002211);
    pc = 32'd8; #1; chk("pad_pc8", instr, NOP_INSTR);
    chk("pad_words", words, 32'd2);

    // Overflow on a 4-word RAM.
    select(1'b1);
    do_reset();
    for (int i = 0; i < 20; i++) pat[i] = 8'($urandom);
    load(pat, 20, 0);
    check_state();
    chk("ovf_words", words, 32'd4);
    chk("ovf_flag",  32'(ovf), 32'd1);
    pc = 32'd12; #1;
    chk("ovf_w3", instr, {pat[15], pat[14], pat[13], pat[12]});

    // Reset in the middle of a load discards the partial word.
    select(1'b0);
    do_reset();
    for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1'b0, 0);
    do_reset();
    v64 = 64'h04030201;
    for (int i = 0; i < 4; i++) send_byte(v64[8*i +: 8], i == 3, 0);
    check_state();
    pc = 32'd0; #1; chk("rst_mid_w0", instr, 32'h04030201);
    chk("rst_mid_words", words, 32'd1);
    chk("rst_mid_ovf", 32'(ovf), 32'd0);

    // In RUN the load port is closed.
    ld_valid = 1'b1;
    ld_last  = 1'b1;
    repeat (5) begin
      ld_byte = 8'($urandom);
      @(posedge clk); #1;
      chk("run_ready", 32'(ready), 32'd0);
      chk("run_hold",  32'(hold),  32'd0);
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    check_state();

    // Gap-free versus gapped loads of the same random stream.
    for (int t = 0; t < 6; t++) begin
      select(1'($urandom_range(0, 1)));
      n = int'($urandom_range(1, sel ? 24 : 40));
      for (int i = 0; i < 64; i++) pat[i] = 8'($urandom);
      do_reset();
      load(pat, n, 0);
      check_state();
      for (int k = 0; k < 12; k++) begin
        pc = 32'(4*k); #1;
        snap[k] = instr;
      end
      do_reset();
      load(pat, n, 3);
      check_state();
      for (int k = 0; k < 12; k++) begin
        pc = 32'(4*k); #1;
        chk("gap_vs_nogap", instr, m_instr(pc));
        chk("gap_snap", snap[k], m_instr(pc));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
